fp_align_unit: RTL

- Operand unpack and exponent-alignment stage for the single-precision FP adder.
- Sits directly upstream of the sum/normalize/round control unit.
- Accepts two IEEE-754 operands and selects the larger-exponent operand.
- Shifts the smaller mantissa right one bit per cycle, preserving guard, round and sticky bits, then presents aligned mantissas plus the common exponent to the SUM stage under a valid/ack handshake.

---
 rtl/fpu_pkg.sv | 14 +
 rtl/fp_unpack.sv | 21 ++
 rtl/fp_align_unit.sv | 111 +++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared widths, constants and align-FSM state encoding for the single-precision adder.
package fpu_pkg;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int EXT_W = MAN_W + 4;
    localparam logic [EXP_W-1:0] EXP_ALL_ONES = '1;
    // 4-bit encoding matches the state width of the downstream control unit
    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_COMPARE = 4'd1,
        S_SHIFT   = 4'd2,
        S_DONE    = 4'd3
    } align_state_t;
endpackage

// File: rtl/fp_unpack.sv
// fp_unpack: splits an IEEE operand into sign, effective exponent and {hidden, fraction, G, R, S}.
module fp_unpack #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [EXP_W+MAN_W:0] op,
    output logic                 sign,
    output logic [EXP_W-1:0]     exp_eff,
    output logic [MAN_W+3:0]     mant,
    output logic                 is_special
);
    logic [EXP_W-1:0] e;
    logic             hidden;
    assign e          = op[EXP_W+MAN_W-1:MAN_W];
    assign hidden     = e != '0;
    assign sign       = op[EXP_W+MAN_W];
    // denormals share the exponent of the smallest normal
    assign exp_eff    = hidden ? e : EXP_W'(1);
    assign mant       = {hidden, op[MAN_W-1:0], 3'b000};
    assign is_special = e == '1;
endmodule

// File: rtl/fp_align_unit.sv
// fp_align_unit: unpacks two operands and right-aligns the smaller mantissa with guard/round/sticky.
// ALIGN_BARREL_SHIFT_EN replaces the 1-bit-per-cycle shifter with a one-cycle barrel shift.
module fp_align_unit import fpu_pkg::*; #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [EXP_W+MAN_W:0] op_a,
    input  logic [EXP_W+MAN_W:0] op_b,
    input  logic                 out_ack,
    output logic                 busy,
    output logic                 out_valid,
    output logic                 sign_l,
    output logic                 sign_s,
    output logic [EXP_W-1:0]     exp_common,
    output logic [MAN_W+3:0]     mant_l,
    output logic [MAN_W+3:0]     mant_s,
    output logic                 swapped,
    output logic                 special
);
    localparam int EXT_W = MAN_W + 4;
    localparam int CW = $clog2(EXT_W + 1);
    align_state_t         state, state_nxt;
    logic [EXP_W+MAN_W:0] a_r, b_r;
    logic [CW-1:0]        count, cnt;
    logic                 sa, sb, spa, spb, a_ge, shift_last, do_shift;
    logic [EXP_W-1:0]     ea, eb, d;
    logic [EXT_W-1:0]     ma, mb, shift_nxt;
    fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
        .op(a_r), .sign(sa), .exp_eff(ea), .mant(ma), .is_special(spa)
    );
    fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
        .op(b_r), .sign(sb), .exp_eff(eb), .mant(mb), .is_special(spb)
    );
    assign a_ge = ea >= eb;
    assign d    = a_ge ? ea - eb : eb - ea;
    // beyond EXT_W places every bit has already collapsed into sticky
    assign cnt  = int'(d) > EXT_W ? CW'(EXT_W) : CW'(d);
`ifdef ALIGN_BARREL_SHIFT_EN
    logic             shift_done;
    logic [EXT_W:0]   mask;
    logic [EXT_W-1:0] shifted;
    assign mask       = {(EXT_W+1){1'b1}} >> (EXT_W - int'(count));
    assign shifted    = mant_s >> count;
    assign shift_nxt  = {shifted[EXT_W-1:1], |({1'b0, mant_s} & mask)};
    assign shift_last = shift_done;
`else
    assign shift_nxt  = {1'b0, mant_s[EXT_W-1:2], mant_s[1] | mant_s[0]};
    assign shift_last = count == '0;
`endif
    assign do_shift = state == S_SHIFT && !shift_last;
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    state_nxt = start ? S_COMPARE : S_IDLE;
            S_COMPARE: state_nxt = (spa | spb) ? S_DONE : S_SHIFT;
            S_SHIFT:   state_nxt = shift_last ? S_DONE : S_SHIFT;
            S_DONE:    state_nxt = out_ack ? S_IDLE : S_DONE;
            default:   state_nxt = S_IDLE;
        endcase
    end
    assign busy      = state != S_IDLE;
    assign out_valid = state == S_DONE;
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            a_r        <= '0;
            b_r        <= '0;
            count      <= '0;
            sign_l     <= 1'b0;
            sign_s     <= 1'b0;
            exp_common <= '0;
            mant_l     <= '0;
            mant_s     <= '0;
            swapped    <= 1'b0;
            special    <= 1'b0;
`ifdef ALIGN_BARREL_SHIFT_EN
            shift_done <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && start) begin
                a_r <= op_a;
                b_r <= op_b;
            end
            if (state == S_COMPARE) begin
                sign_l     <= a_ge ? sa : sb;
                sign_s     <= a_ge ? sb : sa;
                exp_common <= a_ge ? ea : eb;
                mant_l     <= a_ge ? ma : mb;
                mant_s     <= a_ge ? mb : ma;
                swapped    <= !a_ge;
                special    <= spa | spb;
                count      <= cnt;
`ifdef ALIGN_BARREL_SHIFT_EN
                shift_done <= 1'b0;
`endif
            end
            if (do_shift) begin
                mant_s <= shift_nxt;
`ifdef ALIGN_BARREL_SHIFT_EN
                shift_done <= 1'b1;
`else
                count <= count - 1'b1;
`endif
            end
        end
    end
endmodule
